// File: rtl/mips_core_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : mips_core_pkg                                                   |
// | Purpose  : Shared types and constants for the out-of-order MIPS core's     |
// |            physical register file slice.                                   |
// | Contents : DEFAULT_* sizing, preg_addr_t, data_t, PREG_ZERO                 |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package mips_core_pkg;

  localparam int DEFAULT_NUM_PREGS  = 64;
  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int DEFAULT_PREG_W     = $clog2(DEFAULT_NUM_PREGS);

  typedef logic [DEFAULT_PREG_W-1:0]     preg_addr_t;
  typedef logic [DEFAULT_DATA_WIDTH-1:0] data_t;

  // p0 is the hardwired-zero physical register.
  localparam preg_addr_t PREG_ZERO = '0;

endpackage
`default_nettype wire

// File: rtl/phys_reg_file_mp_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : phys_reg_file_mp_if                                             |
// | Purpose  : Bundle of read, writeback and rename-allocation signals of the  |
// |            multi-port physical register file.                              |
// | Modports : master - rename/issue/writeback side (drives requests)          |
// |            slave  - register file side (returns read data, conflict flag)  |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
interface phys_reg_file_mp_if #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_PREGS  = 64,
  parameter int NUM_RD     = 4,
  parameter int NUM_WR     = 2,
  parameter int NUM_ALLOC  = 1
);
  localparam int PREG_W = $clog2(NUM_PREGS);

  logic [NUM_RD-1:0]                 rd_en;
  logic [NUM_RD-1:0][PREG_W-1:0]     rd_addr;
  logic [NUM_RD-1:0][DATA_WIDTH-1:0] rd_data;
  logic [NUM_RD-1:0]                 rd_ready;

  logic [NUM_WR-1:0]                 wr_en;
  logic [NUM_WR-1:0][PREG_W-1:0]     wr_addr;
  logic [NUM_WR-1:0][DATA_WIDTH-1:0] wr_data;

  logic [NUM_ALLOC-1:0]              alloc_en;
  logic [NUM_ALLOC-1:0][PREG_W-1:0]  alloc_addr;

  logic                              wr_conflict;

  modport master (
    output rd_en, rd_addr, wr_en, wr_addr, wr_data, alloc_en, alloc_addr,
    input  rd_data, rd_ready, wr_conflict
  );

  modport slave (
    input  rd_en, rd_addr, wr_en, wr_addr, wr_data, alloc_en, alloc_addr,
    output rd_data, rd_ready, wr_conflict
  );

endinterface
`default_nettype wire

// File: rtl/phys_reg_file_mp_ready_table.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : preg_ready_table                                                |
// | Purpose  : Per-register operand-ready scoreboard. Writeback sets a bit,    |
// |            rename allocation clears it; allocation wins on a same-cycle    |
// |            collision because the allocating instruction is the newer      |
// |            producer. p0 is permanently ready.                              |
// | Ports    : clk, rst (sync, active-high), wr_en/wr_addr, alloc_en/          |
// |            alloc_addr, ready (one bit per physical register)               |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module preg_ready_table #(
  parameter int NUM_PREGS = 64,
  parameter int NUM_WR    = 2,
  parameter int NUM_ALLOC = 1,
  parameter int PREG_W    = $clog2(NUM_PREGS)
) (
  input  wire logic                             clk,
  input  wire logic                             rst,
  input  wire logic [NUM_WR-1:0]                wr_en,
  input  wire logic [NUM_WR-1:0][PREG_W-1:0]    wr_addr,
  input  wire logic [NUM_ALLOC-1:0]             alloc_en,
  input  wire logic [NUM_ALLOC-1:0][PREG_W-1:0] alloc_addr,
  output logic      [NUM_PREGS-1:0]             ready
);

  logic [NUM_PREGS-1:0] r_ready;

  // Allocation loop follows the writeback loop so its clear takes precedence.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ready <= '1;
    end else begin
      for (int i = 0; i < NUM_WR; i++) begin
        if (wr_en[i] && (wr_addr[i] != '0)) begin
          r_ready[wr_addr[i]] <= 1'b1;
        end
      end
      for (int j = 0; j < NUM_ALLOC; j++) begin
        if (alloc_en[j] && (alloc_addr[j] != '0)) begin
          r_ready[alloc_addr[j]] <= 1'b0;
        end
      end
    end
  end

  assign ready = r_ready;

endmodule
`default_nettype wire

// File: rtl/phys_reg_file_mp.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : phys_reg_file_mp                                                |
// | Purpose  : Parametrised multi-port physical register file with ready       |
// |            scoreboard and sticky write-write conflict flag.                |
// | Ports    : clk, rst (sync, active-high), bus (phys_reg_file_mp_if.slave):  |
// |            NUM_RD async read ports, NUM_WR sync write ports, NUM_ALLOC     |
// |            rename allocation ports, wr_conflict.                           |
// | Options  : PHYS_REG_FILE_BYPASS_EN - forward same-cycle writeback data to  |
// |            matching reads (highest write port wins, ready forced to 1).    |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module phys_reg_file_mp
  import mips_core_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int NUM_PREGS  = DEFAULT_NUM_PREGS,
  parameter int NUM_RD     = 4,
  parameter int NUM_WR     = 2,
  parameter int NUM_ALLOC  = 1
) (
  input wire logic           clk,
  input wire logic           rst,
  phys_reg_file_mp_if.slave  bus
);

  localparam int PREG_W = $clog2(NUM_PREGS);

  logic [DATA_WIDTH-1:0]             r_regs [NUM_PREGS];
  logic                              r_conflict;
  logic [NUM_PREGS-1:0]              w_ready;
  logic                              w_conflict;
  logic [NUM_RD-1:0][DATA_WIDTH-1:0] w_rd_data;
  logic [NUM_RD-1:0]                 w_rd_ready;

  preg_ready_table #(
    .NUM_PREGS (NUM_PREGS),
    .NUM_WR    (NUM_WR),
    .NUM_ALLOC (NUM_ALLOC),
    .PREG_W    (PREG_W)
  ) u_ready_table (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (bus.wr_en),
    .wr_addr    (bus.wr_addr),
    .alloc_en   (bus.alloc_en),
    .alloc_addr (bus.alloc_addr),
    .ready      (w_ready)
  );

  // Ascending port order: the highest-index writer lands last and wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NUM_PREGS; k++) begin
        r_regs[k] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_WR; i++) begin
        if (bus.wr_en[i] && (bus.wr_addr[i] != '0)) begin
          r_regs[bus.wr_addr[i]] <= bus.wr_data[i];
        end
      end
    end
  end

  always_comb begin
    w_conflict = 1'b0;
    for (int i = 0; i < NUM_WR; i++) begin
      for (int j = i + 1; j < NUM_WR; j++) begin
        if (bus.wr_en[i] && bus.wr_en[j] &&
            (bus.wr_addr[i] == bus.wr_addr[j]) && (bus.wr_addr[i] != '0)) begin
          w_conflict = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_conflict <= 1'b0;
    end else begin
      r_conflict <= r_conflict | w_conflict;
    end
  end

  // Disabled ports and p0 read as zero/ready; the zero check on rd_addr also
  // keeps a p0 write from ever being forwarded.
  always_comb begin
    w_rd_data  = '0;
    w_rd_ready = '1;
    for (int p = 0; p < NUM_RD; p++) begin
      if (bus.rd_en[p] && (bus.rd_addr[p] != '0)) begin
        w_rd_data[p]  = r_regs[bus.rd_addr[p]];
        w_rd_ready[p] = w_ready[bus.rd_addr[p]];
`ifdef PHYS_REG_FILE_BYPASS_EN
        for (int w = 0; w < NUM_WR; w++) begin
          if (bus.wr_en[w] && (bus.wr_addr[w] == bus.rd_addr[p])) begin
            w_rd_data[p]  = bus.wr_data[w];
            w_rd_ready[p] = 1'b1;
          end
        end
`endif
      end
    end
  end

  assign bus.rd_data     = w_rd_data;
  assign bus.rd_ready    = w_rd_ready;
  assign bus.wr_conflict = r_conflict;

endmodule
`default_nettype wire

// File: tb/tb_phys_reg_file_mp.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_phys_reg_file_mp                                             |
// | Purpose  : Self-checking bench for phys_reg_file_mp. A reference model of  |
// |            the register array, ready bits and conflict flag produces       |
// |            expected read results that are queued and compared.             |
// | Options  : PHYS_REG_FILE_BYPASS_EN - model follows the forwarding variant  |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_phys_reg_file_mp;
  import mips_core_pkg::*;

  localparam int NRD = 4;
  localparam int NWR = 2;
  localparam int NP  = 64;

  typedef struct {
    int          port;
    logic [31:0] data;
    logic        rdy;
  } exp_t;

  logic clk;
  logic rst;
  phys_reg_file_mp_if #(.DATA_WIDTH(32), .NUM_PREGS(NP), .NUM_RD(NRD),
                        .NUM_WR(NWR), .NUM_ALLOC(1)) bus ();

  phys_reg_file_mp #(.DATA_WIDTH(32), .NUM_PREGS(NP), .NUM_RD(NRD),
                     .NUM_WR(NWR), .NUM_ALLOC(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic [31:0] m_data  [NP];
  logic        m_ready [NP];
  logic        m_conf;
  exp_t        sb [$];
  int          n_cmp;
  int          n_err;

  // Advance the model with the inputs presented at this edge.
  task automatic tick();
    logic [31:0] nd [NP];
    logic        nr [NP];
    logic        nc;
    nd = m_data;
    nr = m_ready;
    nc = m_conf;
    if (rst) begin
      for (int k = 0; k < NP; k++) begin
        nd[k] = '0;
        nr[k] = 1'b1;
      end
      nc = 1'b0;
    end else begin
      for (int w = 0; w < NWR; w++) begin
        if (bus.wr_en[w] && bus.wr_addr[w] != 0) begin
          nd[bus.wr_addr[w]] = bus.wr_data[w];
          nr[bus.wr_addr[w]] = 1'b1;
        end
      end
      if (bus.wr_en == 2'b11 && bus.wr_addr[0] == bus.wr_addr[1] && bus.wr_addr[0] != 0)
        nc = 1'b1;
      if (bus.alloc_en[0] && bus.alloc_addr[0] != 0)
        nr[bus.alloc_addr[0]] = 1'b0;
    end
    @(posedge clk);
    #1;
    m_data  = nd;
    m_ready = nr;
    m_conf  = nc;
  endtask

  task automatic idle();
    bus.wr_en    = '0;
    bus.alloc_en = '0;
  endtask

  task automatic read_all(input logic [3:0] en, input int a0, input int a1,
                          input int a2, input int a3);
    bus.rd_en      = en;
    bus.rd_addr[0] = 6'(a0);
    bus.rd_addr[1] = 6'(a1);
    bus.rd_addr[2] = 6'(a2);
    bus.rd_addr[3] = 6'(a3);
  endtask

  task automatic do_write(input int port, input int addr, input logic [31:0] d);
    bus.wr_en[port]   = 1'b1;
    bus.wr_addr[port] = 6'(addr);
    bus.wr_data[port] = d;
  endtask

  // Queue the model's view of every read port, then compare against the DUT.
  task automatic check_reads(input string name);
    exp_t e;
    for (int p = 0; p < NRD; p++) begin
      e.port = p;
      e.data = '0;
      e.rdy  = 1'b1;
      if (bus.rd_en[p] && bus.rd_addr[p] != 0) begin
        e.data = m_data[bus.rd_addr[p]];
        e.rdy  = m_ready[bus.rd_addr[p]];
`ifdef PHYS_REG_FILE_BYPASS_EN
        for (int w = 0; w < NWR; w++) begin
          if (bus.wr_en[w] && bus.wr_addr[w] == bus.rd_addr[p]) begin
            e.data = bus.wr_data[w];
            e.rdy  = 1'b1;
          end
        end
`endif
      end
      sb.push_back(e);
    end
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      n_cmp++;
      if (bus.rd_data[e.port] !== e.data) begin
        n_err++;
        $display("FAIL %s rd_data[%0d] got=%h exp=%h", name, e.port, bus.rd_data[e.port], e.data);
      end
      n_cmp++;
      if (bus.rd_ready[e.port] !== e.rdy) begin
        n_err++;
        $display("FAIL %s rd_ready[%0d] got=%b exp=%b", name, e.port, bus.rd_ready[e.port], e.rdy);
      end
    end
  endtask

  task automatic check_conf(input string name, input logic exp);
    n_cmp++;
    if (bus.wr_conflict !== exp || m_conf !== exp) begin
      n_err++;
      $display("FAIL %s wr_conflict got=%b exp=%b", name, bus.wr_conflict, exp);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    read_all(4'hF, 5, 5, 5, 5);
    tick();
    tick();
    rst = 1'b0;
    check_reads("reset_p5");
    read_all(4'hF, 63, 63, 63, 63);
    check_reads("reset_p63");
    check_conf("reset_conf", 1'b0);
  endtask

  task automatic test_write_read();
    do_write(0, 5, 32'hDEADBEEF);
    tick();
    idle();
    read_all(4'hF, 5, 63, 5, 0);
    check_reads("write_p5");
    n_cmp++;
    if (bus.rd_data[0] !== 32'hDEADBEEF) begin
      n_err++;
      $display("FAIL write_p5_const got=%h exp=%h", bus.rd_data[0], 32'hDEADBEEF);
    end
  endtask

  task automatic test_alloc();
    bus.alloc_en[0]   = 1'b1;
    bus.alloc_addr[0] = 6'd7;
    tick();
    idle();
    read_all(4'hF, 7, 7, 5, 7);
    check_reads("alloc_p7");
    n_cmp++;
    if (bus.rd_ready[0] !== 1'b0) begin
      n_err++;
      $display("FAIL alloc_p7_notready got=%b exp=0", bus.rd_ready[0]);
    end
    tick();
    do_write(1, 7, 32'h12345678);
    tick();
    idle();
    check_reads("alloc_p7_wb");
  endtask

  task automatic test_p0_disabled();
    do_write(0, 0, 32'hFFFFFFFF);
    read_all(4'b1101, 0, 5, 0, 5);
    check_reads("p0_same");
    tick();
    idle();
    check_reads("p0_disabled");
  endtask

  task automatic test_conflict();
    do_write(0, 9, 32'hAAAA0000);
    do_write(1, 9, 32'h5555FFFF);
    tick();
    idle();
    read_all(4'hF, 9, 9, 9, 9);
    check_reads("conflict_p9");
    check_conf("conflict_set", 1'b1);
    repeat (10) tick();
    check_conf("conflict_hold", 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_conf("conflict_clr", 1'b0);
    check_reads("conflict_rst_p9");
  endtask

  task automatic test_alloc_write_same();
    bus.alloc_en[0]   = 1'b1;
    bus.alloc_addr[0] = 6'd12;
    do_write(0, 12, 32'h1);
    tick();
    idle();
    read_all(4'hF, 12, 12, 0, 12);
    check_reads("alloc_wr_p12");
  endtask

  task automatic test_bypass();
    read_all(4'hF, 3, 3, 3, 3);
    do_write(0, 3, 32'hCAFEF00D);
    check_reads("bypass_same");
    tick();
    idle();
    check_reads("bypass_next");
  endtask

  task automatic test_back_to_back();
    for (int c = 0; c < 40; c++) begin
      bus.wr_en         = 2'($urandom_range(0, 3));
      bus.wr_addr[0]    = 6'($urandom_range(0, 15));
      bus.wr_addr[1]    = 6'($urandom_range(0, 15));
      bus.wr_data[0]    = $urandom;
      bus.wr_data[1]    = $urandom;
      bus.alloc_en[0]   = 1'($urandom_range(0, 1));
      bus.alloc_addr[0] = 6'($urandom_range(0, 15));
      read_all(4'($urandom_range(0, 15)), $urandom_range(0, 15), $urandom_range(0, 15),
               $urandom_range(0, 15), $urandom_range(0, 15));
      check_reads("b2b");
      tick();
      check_conf("b2b_conf", m_conf);
    end
    idle();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    n_cmp = 0;
    n_err = 0;
    m_conf = 1'b0;
    for (int k = 0; k < NP; k++) begin
      m_data[k]  = '0;
      m_ready[k] = 1'b1;
    end
    rst = 1'b1;
    bus.rd_en = '0;
    bus.rd_addr = '0;
    bus.wr_en = '0;
    bus.wr_addr = '0;
    bus.wr_data = '0;
    bus.alloc_en = '0;
    bus.alloc_addr = '0;
    test_reset();
    test_write_read();
    test_alloc();
    test_p0_disabled();
    test_conflict();
    test_alloc_write_same();
    test_bypass();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
